// File: rtl/tty_pkg.sv
// Shared types and constants for the teletype serial receive path.
package tty_pkg;

  localparam int DATA_BITS = 8;

  // Receiver framing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/tty_fifo.sv
// Small synchronous FIFO with a registered store and a combinational head.
// Pointers carry one extra wrap bit so full and empty are told apart.
// A push while full is accepted only when a pop happens in the same cycle.
module tty_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  // Pointer and storage update on push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      // NOTE: the store is cleared on reset so the head output reads zero
      // straight out of reset instead of whatever the RAM powered up with.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic, so a
      // same-cycle push and pop both see the pre-edge pointer values.
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_push_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tty_uart_rx.sv
// 8N1 serial receiver for the teletype input: synchronizes the raw pin,
// de-frames characters at mid-bit sample points and queues them, with a
// framing-error flag, for the TTY controller's valid/ready interface.
module tty_uart_rx
  import tty_pkg::*;
#(
  parameter int CLKS_PER_BIT = 454545,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_ferr,
  output logic       overrun,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;

  rx_state_e            r_state;
  rx_state_e            w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [2:0]           r_bitn;
  logic [2:0]           w_bitn_next;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_next;
  logic                 w_cnt_zero;

  logic                 w_push;
  logic [DATA_BITS:0]   w_push_data;
  logic                 w_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS:0]   w_head;
  logic                 r_overrun;

  assign w_rx_s     = r_sync2;
  assign w_cnt_zero = (r_cnt == '0);

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bitn  <= w_bitn_next;
      r_shreg <= w_shreg_next;
    end
  end

  // Framing decisions: next state, timer reloads, sampling and push.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bitn_next  = r_bitn;
    w_shreg_next = r_shreg;
    w_push       = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_cnt_next   = CNT_HALF;
          w_state_next = START;
        end
      end

      START: begin
        if (w_cnt_zero) begin
          if (w_rx_s) begin
            w_state_next = IDLE;          // start bit did not hold: glitch
          end else begin
            w_cnt_next   = CNT_FULL;
            w_bitn_next  = '0;
            w_state_next = DATA;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      DATA: begin
        if (w_cnt_zero) begin
          w_shreg_next = {w_rx_s, r_shreg[DATA_BITS-1:1]};
          w_cnt_next   = CNT_FULL;
          if (r_bitn == LAST_BIT) begin
            w_state_next = STOP;
          end else begin
            w_bitn_next = r_bitn + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      STOP: begin
        if (w_cnt_zero) begin
          w_push       = 1'b1;
          w_state_next = w_rx_s ? IDLE : WAIT_HIGH;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must return high before the next start.
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign w_push_data = {~w_rx_s, r_shreg};
  assign w_pop       = rd_valid && rd_ready;

  tty_fifo #(
    .WIDTH(DATA_BITS + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Flag a completed character that found the buffer full with no pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_fifo_full && !w_pop;
    end
  end

  assign rd_valid = !w_fifo_empty;
  assign rd_data  = w_head[DATA_BITS-1:0];
  assign rd_ferr  = w_head[DATA_BITS];
  assign overrun  = r_overrun;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_tty_uart_rx.sv
// Bench for tty_uart_rx at 16 clocks per bit with a 4-entry buffer.
// A queue-based reference model is advanced once per clock edge from the
// frame timing the bench itself generates; DUT outputs are compared with it
// one time unit after every rising edge.
module tb_tty_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  // Edge, counted from the edge after which the start bit is driven, on
  // which the stop sample lands: 3 (sync + detect) + CPB/2 + 9*CPB.
  localparam int PUSH_EDGE = 3 + CPB / 2 + 9 * CPB;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_ferr;
  logic       overrun;
  logic       busy;

  tty_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_ferr  (rd_ferr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [8:0] mq[$];
  logic       exp_ov;
  logic       push_now;
  logic [8:0] push_val;
  logic       rdy_rand;

  // Observations gathered by the clock-step task.
  byte_q_t got_pops;
  int      busy_cycles;
  int      ov_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance the model, then compare the DUT to it.
  task automatic tick();
    logic pop_m;
    if (rdy_rand) rd_ready = 1'($urandom_range(0, 1));
    if (rd_valid && rd_ready) got_pops.push_back(rd_data);
    pop_m = (mq.size() != 0) && rd_ready;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      exp_ov = 1'b0;
    end else begin
      exp_ov = 1'b0;
      if (pop_m) void'(mq.pop_front());
      if (push_now) begin
        if (mq.size() == DEPTH) exp_ov = 1'b1;   // still full after any pop
        else mq.push_back(push_val);
      end
    end
    push_now = 1'b0;
    #1;
    check("rd_valid", rd_valid, mq.size() != 0);
    check("overrun", overrun, exp_ov);
    if (mq.size() != 0) begin
      check("rd_data", rd_data, mq[0][7:0]);
      check("rd_ferr", rd_ferr, mq[0][8]);
    end
    if (busy) busy_cycles++;
    if (overrun) ov_pulses++;
  endtask

  // Drive one 8N1 frame; optionally assert reset at bit-time index abort_at
  // or raise rd_ready only for the stop-sample cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int abort_at, input logic pop_at_stop);
    for (int i = 0; i < FRAME; i++) begin
      int b = i / CPB;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = data[b-1];
      else             rx = stop_bit;
      if (i == abort_at) begin
        reset = 1'b1;
        return;
      end
      if (i + 1 == PUSH_EDGE) begin
        push_now = 1'b1;
        push_val = {~stop_bit, data};
      end
      if (pop_at_stop) rd_ready = (i + 1 == PUSH_EDGE);
      tick();
    end
  endtask

  task automatic check_pops(input string tag, input byte_q_t exp);
    check({tag, "_count"}, got_pops.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_pops.size(); i++) begin
      check({tag, "_data"}, got_pops[i], exp[i]);
    end
  endtask

  initial begin
    byte_q_t exp_q;
    logic [7:0] d;
    logic       sb;

    reset    = 1'b1;
    rx       = 1'b1;
    rd_ready = 1'b0;
    push_now = 1'b0;
    push_val = '0;
    exp_ov   = 1'b0;
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_ferr", rd_ferr, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) tick();

    // Single character with the consumer always ready.
    rd_ready = 1'b1;
    got_pops.delete(); busy_cycles = 0; ov_pulses = 0;
    send_frame(8'h41, 1'b1, -1, 1'b0);
    repeat (4) tick();
    check("single_busy_cycles", busy_cycles, PUSH_EDGE - 3);
    check("single_overrun", ov_pulses, 0);
    exp_q = '{8'h41};
    check_pops("single", exp_q);

    // Short low glitch on an idle line.
    got_pops.delete(); busy_cycles = 0;
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (20) tick();
    check("glitch_busy_cycles", busy_cycles, 3 + CPB / 2 - 3);
    check("glitch_pops", got_pops.size(), 0);
    check("glitch_busy_end", busy, 1'b0);

    // Framing error followed by a 40-bit break.
    got_pops.delete(); busy_cycles = 0;
    send_frame(8'h55, 1'b0, -1, 1'b0);
    repeat (40 * CPB) tick();
    check("break_busy_held", busy, 1'b1);
    rx = 1'b1;
    repeat (10) tick();
    check("break_busy_cycles", busy_cycles, FRAME + 40 * CPB + 2 - 2);
    exp_q = '{8'h55};
    check_pops("break", exp_q);

    // Overrun: five characters into four slots with no consumer.
    rd_ready = 1'b0;
    got_pops.delete(); ov_pulses = 0;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, -1, 1'b0);
    repeat (4) tick();
    check("overrun_pulses", ov_pulses, 1);
    rd_ready = 1'b1;
    repeat (8) tick();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_pops("overrun", exp_q);
    check("overrun_drained", rd_valid, 1'b0);

    // Full buffer, push and pop in the same cycle.
    rd_ready = 1'b0;
    got_pops.delete(); ov_pulses = 0;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, -1, 1'b0);
    send_frame(8'h7E, 1'b1, -1, 1'b1);
    rd_ready = 1'b0;
    repeat (4) tick();
    check("pushpop_overrun", ov_pulses, 0);
    rd_ready = 1'b1;
    repeat (8) tick();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h7E};
    check_pops("pushpop", exp_q);

    // Reset during data bit 4, then a clean character.
    rd_ready = 1'b0;
    send_frame(8'h07, 1'b1, -1, 1'b0);       // leave one entry queued
    send_frame(8'hFF, 1'b1, 5 * CPB + 5, 1'b0);
    #1;
    check("midrst_rd_valid", rd_valid, 1'b0);
    check("midrst_rd_data", rd_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b1;
    got_pops.delete();
    send_frame(8'h0D, 1'b1, -1, 1'b0);
    repeat (4) tick();
    exp_q = '{8'h0D};
    check_pops("post_reset", exp_q);

    // Random characters, stop bits, gaps and consumer back-pressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, sb, -1, 1'b0);
      if (!sb) begin
        repeat ($urandom_range(1, 3) * CPB) tick();
        rx = 1'b1;
        repeat ($urandom_range(2, 12)) tick();
      end else begin
        repeat ($urandom_range(0, 20)) tick();
      end
    end
    rdy_rand = 1'b0;
    rd_ready = 1'b1;
    repeat (10) tick();
    check("random_drained", rd_valid, 1'b0);
    check("random_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
